// File: rtl/bypass_fifo_n.sv
// Multi-entry circular-buffer FIFO with compile-time bypass or pipeline
// ordering of enqueue against dequeue in the same cycle.
module bypass_fifo_n #(
  parameter  int N         = 32,
  parameter  int DEPTH     = 4,
  parameter  int BYPASS    = 1,
  parameter  int AF_THRESH = DEPTH - 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [N-1:0]  wdata,
  input  logic          re,
  output logic [N-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          almost_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          is_empty;
  logic          is_full;
  logic          enq_fire;
  logic          deq_fire;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == FULL_C);

  // rst gating keeps flags quiet while the async reset is held
  always_comb begin
    full  = 1'b0;
    empty = 1'b1;
    rdata = mem[head];
    if (BYPASS != 0) begin
      full  = !rst && is_full;
      empty = rst || (is_empty && !we);
      rdata = is_empty ? wdata : mem[head];
    end else begin
      full  = !rst && is_full && !re;
      empty = rst || is_empty;
    end
  end

  assign enq_fire = we && !full;
  assign deq_fire = re && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq_fire) tail <= nxt(tail);
      if (deq_fire) head <= nxt(head);
      cnt <= cnt + CW'(enq_fire) - CW'(deq_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) mem[tail] <= wdata;
  end

  assign count       = cnt;
  assign almost_full = (cnt >= AF_C);

endmodule
